// File: rtl/lutram_march_ctrl.sv
// ---------------------------------------------------------------------------
// lutram_march_ctrl
//
// March C- built-in self-test sequencer for a single-port, 1-bit-wide
// distributed RAM (asynchronous read, synchronous write, e.g. RAM256X1S).
// The RAM write clock is clk_i.
//
// Sequence (one element after another, no idle gaps):
//   W0_UP   : 1 cycle/address, write 0
//   R0W1_UP : 2 cycles/address, read expect 0, then write 1
//   R1W0_UP : 2 cycles/address, read expect 1, then write 0
//   R0W1_DN : 2 cycles/address, read expect 0, then write 1
//   R1W0_DN : 2 cycles/address, read expect 1, then write 0
//   R0_DN   : 1 cycle/address, read expect 0
// UP elements walk 0 .. 2^A_WIDTH-1, DN elements walk 2^A_WIDTH-1 .. 0.
//
// Optional feature, macro LUTRAM_MARCH_CHECKERBOARD_EN:
//   when defined, two checkerboard elements (elem_o = 7) follow R0_DN:
//   a write pass with d = addr[0]^addr[1], then a read pass comparing
//   against the same pattern. Requires A_WIDTH >= 2.
//
// Ports:
//   clk_i              test clock, also the RAM WCLK
//   rst_i              asynchronous active-high reset
//   start_i            one-cycle run request (accepted in IDLE/DONE only)
//   busy_o             run in progress
//   done_o             run finished, held until the next accepted start
//   pass_o             valid with done_o: 1 = no mismatches
//   err_count_o        saturating mismatch count of the current/last run
//   first_err_valid_o  at least one mismatch seen this run
//   first_err_addr_o   address of the first mismatch
//   elem_o             current march element (0 in IDLE/DONE)
//   ram_a_o            RAM address
//   ram_d_o            RAM write data
//   ram_we_o           RAM write enable
//   ram_q_i            RAM asynchronous read data
// ---------------------------------------------------------------------------
module lutram_march_ctrl #(
    parameter int A_WIDTH   = 8,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic                 first_err_valid_o,
    output logic [A_WIDTH-1:0]   first_err_addr_o,
    output logic [2:0]           elem_o,
    output logic [A_WIDTH-1:0]   ram_a_o,
    output logic                 ram_d_o,
    output logic                 ram_we_o,
    input  logic                 ram_q_i
);

    // State values 1..6 double as the elem_o encoding.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_W0_UP   = 4'd1,
        ST_R0W1_UP = 4'd2,
        ST_R1W0_UP = 4'd3,
        ST_R0W1_DN = 4'd4,
        ST_R1W0_DN = 4'd5,
        ST_R0_DN   = 4'd6,
        ST_DONE    = 4'd7,
        ST_CB      = 4'd8
    } state_t;

    localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;

    state_t               state;
    logic                 phase;     // 0 = read half, 1 = write half of RxWy
    logic                 cb_sub;    // 0 = checkerboard write, 1 = checkerboard read

    state_t               nxt_state;
    logic                 nxt_phase;
    logic                 nxt_sub;
    logic [A_WIDTH-1:0]   nxt_addr;
    logic                 start_acc;
    logic                 rd_en;
    logic                 rd_exp;
    logic                 mismatch;
    logic                 at_last;
    logic [ERR_WIDTH-1:0] nxt_err;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------
    function automatic logic is_down(input state_t s);
        return (s == ST_R0W1_DN) || (s == ST_R1W0_DN) || (s == ST_R0_DN);
    endfunction

    function automatic state_t succ(input state_t s);
        case (s)
            ST_W0_UP:   return ST_R0W1_UP;
            ST_R0W1_UP: return ST_R1W0_UP;
            ST_R1W0_UP: return ST_R0W1_DN;
            ST_R0W1_DN: return ST_R1W0_DN;
            ST_R1W0_DN: return ST_R0_DN;
`ifdef LUTRAM_MARCH_CHECKERBOARD_EN
            ST_R0_DN:   return ST_CB;
`else
            ST_R0_DN:   return ST_DONE;
`endif
            default:    return ST_DONE;
        endcase
    endfunction

    function automatic logic [A_WIDTH-1:0] first_addr(input state_t s);
        return is_down(s) ? ADDR_MAX : '0;
    endfunction

    function automatic logic cb_bit(input logic [A_WIDTH-1:0] a);
        return a[0] ^ a[1];
    endfunction

    function automatic logic we_of(input state_t s, input logic ph, input logic sb);
        case (s)
            ST_W0_UP:                                        return 1'b1;
            ST_R0W1_UP, ST_R1W0_UP, ST_R0W1_DN, ST_R1W0_DN: return ph;
            ST_CB:                                           return !sb;
            default:                                         return 1'b0;
        endcase
    endfunction

    function automatic logic d_of(input state_t s, input logic ph, input logic sb,
                                  input logic [A_WIDTH-1:0] a);
        case (s)
            ST_R0W1_UP, ST_R0W1_DN: return ph;
            ST_CB:                  return !sb && cb_bit(a);
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] elem_of(input state_t s);
        logic [3:0] sv;
        sv = s;
        case (s)
            ST_W0_UP, ST_R0W1_UP, ST_R1W0_UP,
            ST_R0W1_DN, ST_R1W0_DN, ST_R0_DN: return sv[2:0];
            ST_CB:                             return 3'd7;
            default:                           return 3'd0;
        endcase
    endfunction

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] c);
        return (&c) ? c : c + ERR_WIDTH'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Next-state / compare decode
    // -----------------------------------------------------------------------
    assign at_last = is_down(state) ? (ram_a_o == '0) : (ram_a_o == ADDR_MAX);

    always_comb begin
        nxt_state = state;
        nxt_phase = phase;
        nxt_sub   = cb_sub;
        nxt_addr  = ram_a_o;
        start_acc = 1'b0;
        rd_en     = 1'b0;
        rd_exp    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    nxt_state = ST_W0_UP;
                    nxt_phase = 1'b0;
                    nxt_sub   = 1'b0;
                    nxt_addr  = '0;
                end
            end
            ST_W0_UP, ST_R0_DN: begin
                rd_en  = (state == ST_R0_DN);
                rd_exp = 1'b0;
                if (at_last) begin
                    nxt_state = succ(state);
                    nxt_addr  = first_addr(succ(state));
                    nxt_phase = 1'b0;
                    nxt_sub   = 1'b0;
                end else begin
                    nxt_addr = is_down(state) ? ram_a_o - A_WIDTH'(1) : ram_a_o + A_WIDTH'(1);
                end
            end
            ST_R0W1_UP, ST_R1W0_UP, ST_R0W1_DN, ST_R1W0_DN: begin
                if (!phase) begin
                    rd_en     = 1'b1;
                    rd_exp    = (state == ST_R1W0_UP) || (state == ST_R1W0_DN);
                    nxt_phase = 1'b1;
                end else begin
                    // Address only moves after the write half.
                    nxt_phase = 1'b0;
                    if (at_last) begin
                        nxt_state = succ(state);
                        nxt_addr  = first_addr(succ(state));
                    end else begin
                        nxt_addr = is_down(state) ? ram_a_o - A_WIDTH'(1) : ram_a_o + A_WIDTH'(1);
                    end
                end
            end
`ifdef LUTRAM_MARCH_CHECKERBOARD_EN
            ST_CB: begin
                rd_en  = cb_sub;
                rd_exp = cb_bit(ram_a_o);
                if (at_last) begin
                    nxt_addr = '0;
                    if (cb_sub) begin
                        nxt_state = ST_DONE;
                        nxt_sub   = 1'b0;
                    end else begin
                        nxt_sub = 1'b1;
                    end
                end else begin
                    nxt_addr = ram_a_o + A_WIDTH'(1);
                end
            end
`endif
            default: begin
                nxt_state = ST_IDLE;
                nxt_addr  = '0;
                nxt_phase = 1'b0;
                nxt_sub   = 1'b0;
            end
        endcase
    end

    // Read data is sampled at the edge that ends the read cycle.
    assign mismatch = rd_en && (ram_q_i != rd_exp);
    assign nxt_err  = mismatch ? sat_inc(err_count_o) : err_count_o;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= ST_IDLE;
            phase             <= 1'b0;
            cb_sub            <= 1'b0;
            ram_a_o           <= '0;
            ram_we_o          <= 1'b0;
            ram_d_o           <= 1'b0;
            elem_o            <= 3'd0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            err_count_o       <= '0;
            first_err_valid_o <= 1'b0;
            first_err_addr_o  <= '0;
        end else begin
            state    <= nxt_state;
            phase    <= nxt_phase;
            cb_sub   <= nxt_sub;
            ram_a_o  <= nxt_addr;
            // RAM controls are precomputed from the next state so they are
            // plain flops when the RAM sees them.
            ram_we_o <= we_of(nxt_state, nxt_phase, nxt_sub);
            ram_d_o  <= d_of(nxt_state, nxt_phase, nxt_sub, nxt_addr);
            elem_o   <= elem_of(nxt_state);
            if (start_acc) begin
                busy_o            <= 1'b1;
                done_o            <= 1'b0;
                pass_o            <= 1'b0;
                err_count_o       <= '0;
                first_err_valid_o <= 1'b0;
                first_err_addr_o  <= '0;
            end else begin
                err_count_o <= nxt_err;
                if (mismatch && !first_err_valid_o) begin
                    first_err_valid_o <= 1'b1;
                    first_err_addr_o  <= ram_a_o;
                end
                // pass_o must include a mismatch on the very last read.
                if ((nxt_state == ST_DONE) && (state != ST_DONE)) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= (nxt_err == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lutram_march_ctrl
//
// Bench for lutram_march_ctrl. A behavioural 256x1 RAM with per-cell
// stuck-at-0/1 masks sits on the RAM port. The expected per-cycle operation
// list is generated from the march element definitions, and the expected
// error count / first failing address come from replaying that list against
// a model memory with the same fault masks.
// A second instance with ERR_WIDTH=2 reads an all-ones RAM to exercise
// counter saturation.
// ---------------------------------------------------------------------------
module tb_lutram_march_ctrl;

    localparam int AW = 8;
    localparam int N  = 1 << AW;

    typedef struct packed {
        logic [2:0]    elem;
        logic [AW-1:0] a;
        logic          we;
        logic          d;
        logic          rd;
        logic          exp;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          start2;

    logic          busy, done, pass, fev, ram_d, ram_we, ram_q;
    logic [15:0]   err;
    logic [AW-1:0] fea, ram_a;
    logic [2:0]    elem;

    logic          busy2, done2, pass2, fev2, ram_d2, ram_we2, ram_q2;
    logic [1:0]    err2;
    logic [AW-1:0] fea2, ram_a2;
    logic [2:0]    elem2;

    logic [N-1:0]  mem;
    logic [N-1:0]  sa1;
    logic [N-1:0]  sa0;
    int            wr_cnt = 0;

    op_t           trace[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    lutram_march_ctrl #(.A_WIDTH(AW), .ERR_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(err), .first_err_valid_o(fev), .first_err_addr_o(fea),
        .elem_o(elem), .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_we_o(ram_we),
        .ram_q_i(ram_q)
    );

    lutram_march_ctrl #(.A_WIDTH(AW), .ERR_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .err_count_o(err2), .first_err_valid_o(fev2), .first_err_addr_o(fea2),
        .elem_o(elem2), .ram_a_o(ram_a2), .ram_d_o(ram_d2), .ram_we_o(ram_we2),
        .ram_q_i(ram_q2)
    );

    // Behavioural RAM: async read with stuck-at overrides, sync write.
    assign ram_q  = sa1[ram_a] | (~sa0[ram_a] & mem[ram_a]);
    assign ram_q2 = 1'b1;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_a] <= ram_d;
            wr_cnt     <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic cb_pat(input int a);
        return a[0] ^ a[1];
    endfunction

    function automatic void push_op(input int el, input int a, input bit we,
                                    input bit d, input bit rd, input bit ex);
        op_t o;
        o.elem = 3'(el);
        o.a    = AW'(a);
        o.we   = we;
        o.d    = d;
        o.rd   = rd;
        o.exp  = ex;
        trace.push_back(o);
    endfunction

    // One entry per clock cycle of a run, straight from the element list.
    task automatic build_trace();
        trace.delete();
        for (int i = 0; i < N; i++) push_op(1, i, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) begin
            bit x;
            bit dn;
            x  = (e == 1) || (e == 3);
            dn = (e >= 2);
            for (int i = 0; i < N; i++) begin
                int a;
                a = dn ? N - 1 - i : i;
                push_op(e + 2, a, 1'b0, 1'b0, 1'b1, x);
                push_op(e + 2, a, 1'b1, !x,   1'b0, 1'b0);
            end
        end
        for (int i = 0; i < N; i++) push_op(6, N - 1 - i, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef LUTRAM_MARCH_CHECKERBOARD_EN
        for (int i = 0; i < N; i++) push_op(7, i, 1'b1, cb_pat(i), 1'b0, 1'b0);
        for (int i = 0; i < N; i++) push_op(7, i, 1'b0, 1'b0, 1'b1, cb_pat(i));
`endif
    endtask

    // Replay the operation list on a faulty model memory.
    task automatic model(output int cnt, output int fa, output bit fv);
        logic [N-1:0] mm;
        logic         q;
        mm  = '0;
        cnt = 0;
        fa  = 0;
        fv  = 1'b0;
        foreach (trace[k]) begin
            q = sa1[trace[k].a] | (~sa0[trace[k].a] & mm[trace[k].a]);
            if (trace[k].rd && (q != trace[k].exp)) begin
                if (!fv) begin
                    fv = 1'b1;
                    fa = int'(trace[k].a);
                end
                cnt++;
            end
            if (trace[k].we) mm[trace[k].a] = trace[k].d;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy,   0);
        check({tag, "_done"}, done,   0);
        check({tag, "_pass"}, pass,   0);
        check({tag, "_err"},  err,    0);
        check({tag, "_fev"},  fev,    0);
        check({tag, "_fea"},  fea,    0);
        check({tag, "_elem"}, elem,   0);
        check({tag, "_a"},    ram_a,  0);
        check({tag, "_d"},    ram_d,  0);
        check({tag, "_we"},   ram_we, 0);
    endtask

    // Pulse start, compare every cycle against the trace, then the DONE
    // state. extra_at: cycle index to re-pulse start (-1 = never).
    // abort_at: cycle index to assert reset (-1 = never).
    task automatic run_march(input string name, input int extra_at, input int abort_at);
        int cnt;
        int fa;
        bit fv;
        int snap;
        model(cnt, fa, fv);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < trace.size(); k++) begin
            check({name, "_trace"},
                  {busy, elem, ram_a, ram_we, ram_d & ram_we},
                  {1'b1, trace[k].elem, trace[k].a, trace[k].we, trace[k].d & trace[k].we});
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset({name, "_abort"});
                snap = wr_cnt;
                repeat (3) @(negedge clk);
                check({name, "_no_wr"}, wr_cnt, snap);
                check({name, "_we_held"}, ram_we, 0);
                rst = 1'b0;
                return;
            end
            start = (k == extra_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_end"}, busy, 0);
        check({name, "_done"},     done, 1);
        check({name, "_pass"},     pass, (cnt == 0));
        check({name, "_err"},      err,  (cnt > 65535) ? 65535 : cnt);
        check({name, "_fev"},      fev,  fv);
        check({name, "_fea"},      fea,  fa);
        check({name, "_elem_end"}, elem, 0);
        check({name, "_we_end"},   ram_we, 0);
    endtask

    initial begin
        int w;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        sa1    = '0;
        sa0    = '0;
        mem    = '0;
        build_trace();
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // Fault-free run.
        run_march("clean", -1, -1);

        // Single stuck-at-1 cell.
        sa1[8'h5A] = 1'b1;
        run_march("sa1_5a", -1, -1);
        check("sa1_5a_cnt_lit",  err, 3);
        check("sa1_5a_addr_lit", fea, 8'h5A);
        sa1 = '0;

        // Stuck-at-0 at both ends of the address space.
        sa0[8'h00] = 1'b1;
        sa0[8'hFF] = 1'b1;
        run_march("sa0_ends", -1, -1);
        check("sa0_ends_cnt_lit",  err, 4);
        check("sa0_ends_addr_lit", fea, 8'h00);
        sa0 = '0;

        // Start while busy is ignored; trace must still match.
        run_march("restart", 100, -1);

        // Reset during R1W0_DN, then a full clean run.
        run_march("abort", -1, N + 3 * 2 * N + 37);
        run_march("after_abort", -1, -1);

        // Randomized fault patterns and stray starts.
        for (int r = 0; r < 4; r++) begin
            int nf;
            int a;
            sa1 = '0;
            sa0 = '0;
            nf  = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) begin
                a = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 1) sa1[a] = 1'b1;
                else                           sa0[a] = 1'b1;
            end
            run_march("rand", int'($urandom_range(0, 2000)), -1);
        end

        // Every cell stuck at 1.
        sa1 = '1;
        sa0 = '0;
        run_march("all_sa1", -1, -1);
        check("all_sa1_addr_lit", fea, 0);
        sa1 = '0;

        // ERR_WIDTH=2 instance on an all-ones RAM saturates at 3.
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        w = 0;
        while (!done2 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("sat_done", done2, 1);
        check("sat_err",  err2,  3);
        check("sat_pass", pass2, 0);
        check("sat_fev",  fev2,  1);
        check("sat_fea",  fea2,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
